// File: rtl/isr_pkg.sv
// Shared constants and FSM state type for the ISR request front-end.
package isr_pkg;

    localparam int unsigned VAL_W = 64;
    localparam int unsigned RES_W = 32;

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StRun
    } isr_feeder_state_e;

endpackage

// File: rtl/isr_feeder_if.sv
// Operand/result streams plus the ISR load/done link of the feeder.
interface isr_feeder_if #(
    parameter int unsigned CNT_W = 16
);

    logic              in_valid;
    logic              in_ready;
    logic [63:0]       in_value;
    logic              out_valid;
    logic              out_ready;
    logic [63:0]       out_value;
    logic [31:0]       out_result;
    logic [CNT_W-1:0]  out_cycles;
    logic              isr_reset;
    logic [63:0]       isr_value;
    logic [31:0]       isr_result;
    logic              isr_done;

    modport slave (
        input  in_valid, in_value, out_ready, isr_result, isr_done,
        output in_ready, out_valid, out_value, out_result, out_cycles, isr_reset, isr_value
    );

    modport master (
        output in_valid, in_value, out_ready, isr_result, isr_done,
        input  in_ready, out_valid, out_value, out_result, out_cycles, isr_reset, isr_value
    );

endinterface

// File: rtl/isr_req_fifo.sv
// Operand FIFO with wrap-bit pointers; no bypass, push and pop may coincide.
module isr_req_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 64
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [AW:0]      wr_q, rd_q;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push, do_pop;

    assign empty    = (wr_q == rd_q);
    assign full     = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem_q[rd_q[AW-1:0]];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            if (do_push) wr_q <= wr_q + {{AW{1'b0}}, 1'b1};
            if (do_pop)  rd_q <= rd_q + {{AW{1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clock) begin
        if (do_push) mem_q[wr_q[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/isr_feeder.sv
// Sequences queued operands through the ISR unit and returns operand, root and cycle count.
// Optional root checker and check_err port enabled by ISR_FEEDER_CHECK_EN.
module isr_feeder
    import isr_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CNT_W = 16
) (
    input  logic        clock,
    input  logic        reset,
    isr_feeder_if.slave bus,
    output logic        busy
`ifdef ISR_FEEDER_CHECK_EN
    ,
    output logic        check_err
`endif
);

    isr_feeder_state_e state_q, state_d;

    logic [VAL_W-1:0] fifo_head;
    logic             fifo_full, fifo_empty;
    logic             start, capture, out_pop;

    logic [VAL_W-1:0] operand_q, operand_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             out_valid_q, out_valid_d;
    logic [VAL_W-1:0] out_value_q, out_value_d;
    logic [RES_W-1:0] out_result_q, out_result_d;
    logic [CNT_W-1:0] out_cycles_q, out_cycles_d;
    logic             isr_reset_q, isr_reset_d;

    assign out_pop = out_valid_q && bus.out_ready;
    // Start only when the result slot is free or being emptied this cycle.
    assign start   = (state_q == StIdle) && !fifo_empty && (!out_valid_q || bus.out_ready);
    assign capture = (state_q == StRun) && bus.isr_done;

    isr_req_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (VAL_W)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (bus.in_valid),
        .push_data (bus.in_value),
        .pop       (start),
        .pop_data  (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state_q <= StIdle;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (start) state_d = StLoad;
            StLoad:  state_d = StRun;
            StRun:   if (bus.isr_done) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        operand_d    = start ? fifo_head : operand_q;
        cnt_d        = cnt_q;
        out_valid_d  = out_valid_q;
        out_value_d  = out_value_q;
        out_result_d = out_result_q;
        out_cycles_d = out_cycles_q;
        isr_reset_d  = (state_d != StRun);
        if (state_q == StLoad) begin
            cnt_d = '0;
        end else if (state_q == StRun && cnt_q != {CNT_W{1'b1}}) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
        if (capture) begin
            out_valid_d  = 1'b1;
            out_value_d  = operand_q;
            out_result_d = bus.isr_result;
            out_cycles_d = cnt_q;
        end else if (out_pop) begin
            out_valid_d  = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            operand_q    <= '0;
            cnt_q        <= '0;
            out_valid_q  <= 1'b0;
            out_value_q  <= '0;
            out_result_q <= '0;
            out_cycles_q <= '0;
            isr_reset_q  <= 1'b1;
        end else begin
            operand_q    <= operand_d;
            cnt_q        <= cnt_d;
            out_valid_q  <= out_valid_d;
            out_value_q  <= out_value_d;
            out_result_q <= out_result_d;
            out_cycles_q <= out_cycles_d;
            isr_reset_q  <= isr_reset_d;
        end
    end

    assign bus.in_ready   = !fifo_full;
    assign bus.out_valid  = out_valid_q;
    assign bus.out_value  = out_value_q;
    assign bus.out_result = out_result_q;
    assign bus.out_cycles = out_cycles_q;
    assign bus.isr_reset  = isr_reset_q;
    assign bus.isr_value  = operand_q;
    assign busy           = (state_q != StIdle) || !fifo_empty;

`ifdef ISR_FEEDER_CHECK_EN
    logic [65:0] r_ext, v_ext;
    logic        root_ok, err_q;

    // 66 bits so (r+1)^2 for r = 2^32-1 cannot overflow.
    assign r_ext   = 66'(bus.isr_result);
    assign v_ext   = 66'(operand_q);
    assign root_ok = (r_ext * r_ext <= v_ext) && ((r_ext + 66'd1) * (r_ext + 66'd1) > v_ext);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset)                   err_q <= 1'b0;
        else if (capture && !root_ok) err_q <= 1'b1;
    end

    assign check_err = err_q;
`endif

endmodule

// File: tb/tb_isr_feeder.sv
// Bench for isr_feeder: behavioural bit-serial ISR, stub mode and result scoreboard.
module tb_isr_feeder;

    localparam int unsigned DEPTH   = 4;
    localparam int unsigned CNT_W   = 16;
    localparam int unsigned ISR_LAT = 32;

    typedef struct {
        logic [63:0]      v;
        logic [31:0]      r;
        logic [CNT_W-1:0] c;
    } exp_t;

    logic clock = 1'b0;
    logic reset = 1'b0;
    logic busy;
`ifdef ISR_FEEDER_CHECK_EN
    logic check_err;
`endif

    int n_checks = 0;
    int n_errors = 0;
    bit sb_en = 1'b1;
    exp_t sb_q[$];

    logic        stub_mode   = 1'b0;
    logic        stub_done   = 1'b0;
    logic [31:0] stub_result = '0;

    isr_feeder_if #(.CNT_W(CNT_W)) bus ();

    isr_feeder #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .bus       (bus),
        .busy      (busy)
`ifdef ISR_FEEDER_CHECK_EN
        ,
        .check_err (check_err)
`endif
    );

    always #5 clock = ~clock;

    // Behavioural ISR: loads while isr_reset is high, then one root bit per cycle.
    logic [63:0] m_val  = '0;
    logic [31:0] m_root = '0;
    logic [35:0] m_rem  = '0;
    int          m_cnt  = 0;
    logic        m_done = 1'b0;

    always @(posedge clock) begin
        logic [35:0] rem_n, trial;
        if (bus.isr_reset) begin
            m_val  <= bus.isr_value;
            m_root <= '0;
            m_rem  <= '0;
            m_cnt  <= 0;
            m_done <= 1'b0;
        end else if (m_cnt < 32) begin
            rem_n = {m_rem[33:0], m_val[63:62]};
            trial = {2'b00, m_root, 2'b01};
            if (rem_n >= trial) begin
                m_rem  <= rem_n - trial;
                m_root <= {m_root[30:0], 1'b1};
            end else begin
                m_rem  <= rem_n;
                m_root <= {m_root[30:0], 1'b0};
            end
            m_val  <= {m_val[61:0], 2'b00};
            m_cnt  <= m_cnt + 1;
            m_done <= (m_cnt == 31);
        end
    end

    assign bus.isr_result = stub_mode ? stub_result : m_root;
    assign bus.isr_done   = stub_mode ? stub_done   : m_done;

    function automatic logic [31:0] ref_sqrt(input logic [63:0] v);
        logic [31:0] r = '0;
        logic [31:0] t;
        for (int b = 31; b >= 0; b--) begin
            t = r | (32'd1 << b);
            if ({32'd0, t} * {32'd0, t} <= v) r = t;
        end
        return r;
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic push(input logic [63:0] v, input int max_cyc, output bit ok);
        ok = 1'b0;
        @(negedge clock);
        bus.in_valid = 1'b1;
        bus.in_value = v;
        for (int i = 0; i < max_cyc; i++) begin
            if (bus.in_ready) begin
                @(posedge clock);
                ok = 1'b1;
                break;
            end
            @(negedge clock);
        end
        #1 bus.in_valid = 1'b0;
        if (ok && sb_en) sb_q.push_back('{v, ref_sqrt(v), CNT_W'(ISR_LAT)});
    endtask

    task automatic drain(input int max_cyc);
        for (int i = 0; i < max_cyc; i++) begin
            if (sb_q.size() == 0) break;
            @(negedge clock);
        end
        check("drain", 64'(sb_q.size()), 64'd0);
    endtask

    always @(negedge clock) begin
        exp_t e;
        if (reset && sb_en && bus.out_valid && bus.out_ready) begin
            if (sb_q.size() == 0) begin
                check("sb_unexpected", 64'd1, 64'd0);
            end else begin
                e = sb_q.pop_front();
                check("out_value", bus.out_value, e.v);
                check("out_result", 64'(bus.out_result), 64'(e.r));
                check("out_cycles", 64'(bus.out_cycles), 64'(e.c));
            end
        end
    end

    initial begin
        bit ok;
        bit seen;
        int accepted;
        logic [63:0] vals[3];
        vals[0] = 64'd24;
        vals[1] = 64'd0;
        vals[2] = 64'hFFFF_FFFF_FFFF_FFFF;

        bus.in_valid  = 1'b0;
        bus.in_value  = '0;
        bus.out_ready = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        check("rst_in_ready", bus.in_ready, 1);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_out_value", bus.out_value, 0);
        check("rst_out_result", 64'(bus.out_result), 0);
        check("rst_out_cycles", 64'(bus.out_cycles), 0);
        check("rst_isr_reset", bus.isr_reset, 1);
        check("rst_isr_value", bus.isr_value, 0);
        check("rst_busy", busy, 0);
`ifdef ISR_FEEDER_CHECK_EN
        check("rst_check_err", check_err, 0);
`endif
        @(negedge clock);
        reset = 1'b1;

        // Single operand
        @(posedge clock);
        #1 bus.out_ready = 1'b1;
        push(64'h4000_0000_0000_0000, 10, ok);
        check("single_accept", ok, 1);
        drain(200);
`ifdef ISR_FEEDER_CHECK_EN
        check("single_check_err", check_err, 0);
`endif

        // Back-to-back operands
        foreach (vals[i]) begin
            push(vals[i], 10, ok);
            check("b2b_accept", ok, 1);
        end
        drain(400);

        // Backpressure: DEPTH queued plus one held result
        @(posedge clock);
        #1 bus.out_ready = 1'b0;
        accepted = 0;
        for (int k = 0; k < 8; k++) begin
            push(64'd100 + 64'(k * 37), 100, ok);
            if (!ok) break;
            accepted++;
        end
        check("bp_accepted", 64'(accepted), 64'(DEPTH + 1));
        check("bp_in_ready_low", bus.in_ready, 0);
        check("bp_busy", busy, 1);
        @(posedge clock);
        #1 bus.out_ready = 1'b1;
        @(posedge clock);
        #1 check("bp_in_ready_back", bus.in_ready, 1);
        drain(1000);

        // Asynchronous reset in the middle of RUN
        push(64'd999, 10, ok);
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            if (!bus.isr_reset) begin
                seen = 1'b1;
                break;
            end
        end
        check("run_seen", seen, 1);
        repeat (5) @(negedge clock);
        reset = 1'b0;
        sb_q.delete();
        #1;
        check("mid_isr_reset", bus.isr_reset, 1);
        check("mid_out_valid", bus.out_valid, 0);
        check("mid_in_ready", bus.in_ready, 1);
        check("mid_busy", busy, 0);
        @(negedge clock);
        reset = 1'b1;
        push(64'd1001, 10, ok);
        check("post_rst_root", 64'(ref_sqrt(64'd1001)), 64'd31);
        drain(200);

        // Stubbed done outside RUN must not capture
        @(negedge clock);
        sb_en       = 1'b0;
        stub_mode   = 1'b1;
        stub_done   = 1'b1;
        stub_result = 32'd0;
        repeat (4) begin
            @(posedge clock);
            #1 check("idle_done", bus.out_valid, 0);
        end
        push(64'd24, 10, ok);
        check("stub_accept", ok, 1);
        @(posedge clock);
        #1 check("load_done", bus.out_valid, 0);
        @(posedge clock);
        #1 stub_done = 1'b0;
        check("load_done_run", bus.out_valid, 0);
        repeat (3) @(posedge clock);
        #1 stub_result = 32'd4;
        stub_done = 1'b1;
        @(posedge clock);
        #1 stub_done = 1'b0;
        check("stub_valid", bus.out_valid, 1);
        check("stub_result", 64'(bus.out_result), 64'd4);
        check("stub_value", bus.out_value, 64'd24);
        check("stub_cycles", 64'(bus.out_cycles), 64'd3);
        repeat (2) @(posedge clock);
        #1;

`ifdef ISR_FEEDER_CHECK_EN
        check("stub_ok_err", check_err, 0);
        push(64'd24, 10, ok);
        @(posedge clock);
        @(posedge clock);
        #1 stub_result = 32'd5;
        stub_done = 1'b1;
        @(posedge clock);
        #1 stub_done = 1'b0;
        check("check_err_set", check_err, 1);
        repeat (5) @(posedge clock);
        #1 check("check_err_sticky", check_err, 1);
        @(negedge clock);
        reset = 1'b0;
        #1 check("check_err_clear", check_err, 0);
        @(negedge clock);
        reset = 1'b1;
`endif

        stub_mode = 1'b0;
        repeat (2) @(posedge clock);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish, got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
